// File: rtl/vga_layer_renderer.sv
// -----------------------------------------------------------------------------
// vga_layer_renderer
//
// Purpose:
//   Two-stage pixel renderer. It draws one player box and NUM_OBST obstacle
//   boxes, each with its own enable, over a background colour. It also records
//   which obstacles overlapped the player during a frame, for the game FSM.
//   The block sits between the VGA timing generator and the DAC/VGA pins.
//
//   Stage 1 registers the hit tests for the player and for every obstacle, plus
//   active_pixels. Stage 2 registers the resolved colour and pix_valid.
//   Latency from x/y/active_pixels to RGB/pix_valid is exactly 2 clocks.
//
// Optional build macro:
//   VGA_RENDER_OUTLINE_EN - When defined, obstacle pixels on the outermost
//                           row or column of their box render white. Interior
//                           obstacle pixels render OBST_RGB.
//
// Ports:
//   clk            in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   x, y           in   current pixel column / row
//   active_pixels  in   high inside the visible region
//   frame_start    in   one-cycle pulse at the first pixel of each frame
//   player_x       in   player left edge
//   obstacle_x/y   in   packed obstacle left/top edges;
//                       obstacle i is in slice [i*COORD_W +: COORD_W]
//   obstacle_w/h   in   packed obstacle widths/heights
//   obstacle_en    in   per-obstacle enable
//   VGA_R/G/B      out  registered colour; 0 during blanking
//   pix_valid      out  active_pixels aligned with RGB
//   collision      out  player overlapped any obstacle in the previous frame
//   collision_mask out  per-obstacle overlap flags for the previous frame
// -----------------------------------------------------------------------------
module vga_layer_renderer #(
  parameter int          NUM_OBST    = 4,
  parameter int          COORD_W     = 10,
  parameter int          BOX_WIDTH   = 30,
  parameter int          BOX_HEIGHT  = 30,
  parameter int          BOX_Y_START = 315,
  parameter logic [23:0] BG_RGB      = 24'h506070,
  parameter logic [23:0] PLAYER_RGB  = 24'hFF0000,
  parameter logic [23:0] OBST_RGB    = 24'h00FF00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         active_pixels,
  input  logic                         frame_start,
  input  logic [COORD_W-1:0]           player_x,
  input  logic [NUM_OBST*COORD_W-1:0]  obstacle_x,
  input  logic [NUM_OBST*COORD_W-1:0]  obstacle_y,
  input  logic [NUM_OBST*COORD_W-1:0]  obstacle_w,
  input  logic [NUM_OBST*COORD_W-1:0]  obstacle_h,
  input  logic [NUM_OBST-1:0]          obstacle_en,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         pix_valid,
  output logic                         collision,
  output logic [NUM_OBST-1:0]          collision_mask
);

  // Edge + size sums use one extra bit, so a box that runs past the top of the
  // coordinate range is clipped instead of wrapping back to small coordinates.
  localparam int XW = COORD_W + 1;
  localparam logic [XW-1:0] C_PW     = XW'(BOX_WIDTH);
  localparam logic [XW-1:0] C_PY_TOP = XW'(BOX_Y_START);
  localparam logic [XW-1:0] C_PY_BOT = XW'(BOX_Y_START + BOX_HEIGHT);

  logic [XW-1:0]       w_x_ext;
  logic [XW-1:0]       w_y_ext;
  logic [XW-1:0]       w_px_l;
  logic [XW-1:0]       w_px_r;
  logic                w_player_hit;
  logic [NUM_OBST-1:0] w_obst_hit;

  // Stage-1 registers
  logic                r_s1_active;
  logic                r_s1_player;
  logic [NUM_OBST-1:0] r_s1_obst;

  // Stage-2 / output registers
  logic [23:0]         w_rgb_next;
  logic [23:0]         r_rgb;
  logic                r_pix_valid;

  // Collision accumulator
  logic [NUM_OBST-1:0] w_hit_now;
  logic [NUM_OBST-1:0] w_acc_merged;
  logic [NUM_OBST-1:0] r_acc_mask;
  logic [NUM_OBST-1:0] r_collision_mask;
  logic                r_collision;

`ifdef VGA_RENDER_OUTLINE_EN
  logic [NUM_OBST-1:0] w_obst_edge;
  logic [NUM_OBST-1:0] r_s1_edge;
`endif

  assign w_x_ext = {1'b0, x};
  assign w_y_ext = {1'b0, y};
  assign w_px_l  = {1'b0, player_x};
  assign w_px_r  = w_px_l + C_PW;

  assign w_player_hit = (w_x_ext >= w_px_l)   && (w_x_ext < w_px_r) &&
                        (w_y_ext >= C_PY_TOP) && (w_y_ext < C_PY_BOT);

  // Per-obstacle hit test using half-open bounds [left, left+w) x [top, top+h).
  // A zero size gives an empty range, so that obstacle covers no pixel.
  generate
    for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_obst
      logic [XW-1:0] w_l;
      logic [XW-1:0] w_r;
      logic [XW-1:0] w_t;
      logic [XW-1:0] w_b;

      assign w_l = {1'b0, obstacle_x[gi*COORD_W +: COORD_W]};
      assign w_t = {1'b0, obstacle_y[gi*COORD_W +: COORD_W]};
      assign w_r = w_l + {1'b0, obstacle_w[gi*COORD_W +: COORD_W]};
      assign w_b = w_t + {1'b0, obstacle_h[gi*COORD_W +: COORD_W]};

      assign w_obst_hit[gi] = obstacle_en[gi] &&
                              (w_x_ext >= w_l) && (w_x_ext < w_r) &&
                              (w_y_ext >= w_t) && (w_y_ext < w_b);

`ifdef VGA_RENDER_OUTLINE_EN
      // Only qualified by the hit. The r-1 / b-1 terms are then meaningful
      // because the hit already guarantees a non-empty box.
      assign w_obst_edge[gi] = w_obst_hit[gi] &&
                               ((w_x_ext == w_l) || (w_x_ext == w_r - XW'(1)) ||
                                (w_y_ext == w_t) || (w_y_ext == w_b - XW'(1)));
`endif
    end
  endgenerate

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_active <= 1'b0;
      r_s1_player <= 1'b0;
      r_s1_obst   <= '0;
`ifdef VGA_RENDER_OUTLINE_EN
      r_s1_edge   <= '0;
`endif
    end else begin
      r_s1_active <= active_pixels;
      r_s1_player <= w_player_hit;
      r_s1_obst   <= w_obst_hit;
`ifdef VGA_RENDER_OUTLINE_EN
      r_s1_edge   <= w_obst_edge;
`endif
    end
  end

  // Colour resolution: blanking > player > obstacle > background.
  always_comb begin
    w_rgb_next = 24'h000000;
    if (r_s1_active) begin
      if (r_s1_player) begin
        w_rgb_next = PLAYER_RGB;
      end else if (|r_s1_obst) begin
`ifdef VGA_RENDER_OUTLINE_EN
        // If any covering obstacle has its border here, the pixel is white.
        w_rgb_next = (|r_s1_edge) ? 24'hFFFFFF : OBST_RGB;
`else
        w_rgb_next = OBST_RGB;
`endif
      end else begin
        w_rgb_next = BG_RGB;
      end
    end
  end

  // Stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= 24'h000000;
      r_pix_valid <= 1'b0;
    end else begin
      r_rgb       <= w_rgb_next;
      r_pix_valid <= r_s1_active;
    end
  end

  // A hit is recorded only for visible pixels. A hit that arrives in the same
  // cycle as frame_start is merged into the frame that is closing.
  assign w_hit_now    = r_s1_active ? (r_s1_obst & {NUM_OBST{r_s1_player}}) : '0;
  assign w_acc_merged = r_acc_mask | w_hit_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_mask       <= '0;
      r_collision_mask <= '0;
      r_collision      <= 1'b0;
    end else if (frame_start) begin
      r_collision_mask <= w_acc_merged;
      r_collision      <= |w_acc_merged;
      r_acc_mask       <= '0;
    end else begin
      r_acc_mask       <= w_acc_merged;
    end
  end

  assign VGA_R          = r_rgb[23:16];
  assign VGA_G          = r_rgb[15:8];
  assign VGA_B          = r_rgb[7:0];
  assign pix_valid      = r_pix_valid;
  assign collision      = r_collision;
  assign collision_mask = r_collision_mask;

endmodule

// File: tb/tb_vga_layer_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_layer_renderer
//
// Directed testbench for vga_layer_renderer with default parameters.
// Each scenario is a task that drives the stimulus and checks the results
// inline. Expected colours and masks are worked out by hand from the box
// geometry.
// -----------------------------------------------------------------------------
module tb_vga_layer_renderer;

  localparam int NO = 4;
  localparam int CW = 10;
  localparam logic [23:0] C_BG  = 24'h506070;
  localparam logic [23:0] C_PL  = 24'hFF0000;
  localparam logic [23:0] C_OB  = 24'h00FF00;
  localparam logic [23:0] C_WH  = 24'hFFFFFF;
  localparam logic [23:0] C_OFF = 24'h000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CW-1:0]     x, y, player_x;
  logic              active_pixels, frame_start;
  logic [NO*CW-1:0]  obstacle_x, obstacle_y, obstacle_w, obstacle_h;
  logic [NO-1:0]     obstacle_en;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              pix_valid, collision;
  logic [NO-1:0]     collision_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_layer_renderer #(.NUM_OBST(NO), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .active_pixels(active_pixels), .frame_start(frame_start),
    .player_x(player_x),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .obstacle_w(obstacle_w), .obstacle_h(obstacle_h),
    .obstacle_en(obstacle_en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid), .collision(collision),
    .collision_mask(collision_mask)
  );

  task automatic set_obst(input int i, input int ox, input int oy,
                          input int ow, input int oh, input logic en);
    obstacle_x[i*CW +: CW] = ox[CW-1:0];
    obstacle_y[i*CW +: CW] = oy[CW-1:0];
    obstacle_w[i*CW +: CW] = ow[CW-1:0];
    obstacle_h[i*CW +: CW] = oh[CW-1:0];
    obstacle_en[i]         = en;
  endtask

  task automatic clear_obst();
    for (int i = 0; i < NO; i++) set_obst(i, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    active_pixels = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a single active pixel framed by blanking cycles. The task checks
  // three things: the result is not visible after one clock, it is visible
  // after exactly two clocks, and blanking returns on the following clock.
  // It assumes the previous two input cycles were blanking.
  task automatic check_pixel(input string name, input int px, input int py,
                             input logic [23:0] exp);
    x = px[CW-1:0];
    y = py[CW-1:0];
    active_pixels = 1'b1;
    @(posedge clk); #1;
    active_pixels = 1'b0;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== C_OFF || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: rgb=%06h pv=%b, required rgb=000000 pv=0",
               name, {VGA_R, VGA_G, VGA_B}, pix_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== exp || pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: rgb=%06h pv=%b, required rgb=%06h pv=1",
               name, {VGA_R, VGA_G, VGA_B}, pix_valid, exp);
    end else begin
      $display("pixel %s (%0d,%0d) rgb=%06h", name, px, py, exp);
    end
    @(posedge clk); #1;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== C_OFF || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_late: rgb=%06h pv=%b, required rgb=000000 pv=0",
               name, {VGA_R, VGA_G, VGA_B}, pix_valid);
    end
  endtask

  task automatic pulse_frame(input string name, input logic exp_c,
                             input logic [NO-1:0] exp_m);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    checks++;
    if (collision !== exp_c || collision_mask !== exp_m) begin
      errors++;
      $display("FAIL %s: collision=%b mask=%b, required collision=%b mask=%b",
               name, collision, collision_mask, exp_c, exp_m);
    end else begin
      $display("frame %s collision=%b mask=%b", name, collision, collision_mask);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x = '0; y = '0; active_pixels = 1'b1; frame_start = 1'b0;
    player_x = 10'd100;
    clear_obst();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== C_OFF || pix_valid !== 1'b0 ||
        collision !== 1'b0 || collision_mask !== 4'b0000) begin
      errors++;
      $display("FAIL reset: rgb=%06h pv=%b col=%b mask=%b, required all zero",
               {VGA_R, VGA_G, VGA_B}, pix_valid, collision, collision_mask);
    end else begin
      $display("reset outputs zero");
    end
    rst_n = 1'b1;
    idle(2);
    check_pixel("rst_bg", 0, 0, C_BG);
  endtask

  task automatic test_priority();
    player_x = 10'd100;
    clear_obst();
    set_obst(0, 110, 320, 40, 40, 1'b1);
    check_pixel("prio_player", 115, 325, C_PL);
    check_pixel("prio_obst", 145, 330, C_OB);
    check_pixel("prio_bg", 300, 100, C_BG);
  endtask

  task automatic test_edge_wrap();
    clear_obst();
    set_obst(1, 630, 0, 20, 10, 1'b1);
    check_pixel("edge_first", 630, 0, C_OB);
    check_pixel("edge_last", 639, 9, C_OB);
    check_pixel("edge_left_out", 629, 5, C_BG);
    check_pixel("edge_nowrap0", 0, 5, C_BG);
    check_pixel("edge_below", 635, 10, C_BG);
    // The 10-bit sum 1020+10 would wrap around; the box must still cover 1022.
    set_obst(1, 1020, 0, 10, 10, 1'b1);
    check_pixel("edge_hi", 1022, 5, C_OB);
    check_pixel("edge_hi_nowrap", 3, 5, C_BG);
    set_obst(1, 0, 0, 0, 0, 1'b0);
    set_obst(2, 300, 200, 0, 5, 1'b1);
    set_obst(3, 400, 200, 5, 0, 1'b1);
    check_pixel("zero_w", 300, 200, C_BG);
    check_pixel("zero_h", 400, 200, C_BG);
  endtask

  task automatic test_collision();
    player_x = 10'd100;
    clear_obst();
    // The only earlier hit was (115,325), by obstacle 0 in the priority test.
    pulse_frame("coll_prior", 1'b1, 4'b0001);
    set_obst(0, 110, 320, 40, 40, 1'b1);
    set_obst(1, 500, 10, 10, 10, 1'b1);
    set_obst(2, 90, 300, 20, 20, 1'b1);
    set_obst(3, 120, 330, 10, 10, 1'b0);
    check_pixel("coll_p_o0", 115, 325, C_PL);
    check_pixel("coll_p_o2", 105, 316, C_PL);
    check_pixel("coll_p_o3dis", 125, 335, C_PL);
    check_pixel("coll_o1_only", 505, 15, C_OB);
    pulse_frame("coll_n", 1'b1, 4'b0101);
    check_pixel("coll_n1_o1", 505, 15, C_OB);
    check_pixel("coll_n1_bg", 200, 200, C_BG);
    checks++;
    if (collision !== 1'b1 || collision_mask !== 4'b0101) begin
      errors++;
      $display("FAIL coll_hold: collision=%b mask=%b, required collision=1 mask=0101",
               collision, collision_mask);
    end
    pulse_frame("coll_n1", 1'b0, 4'b0000);
    check_pixel("coll_n2_hit", 115, 325, C_PL);
    pulse_frame("coll_n2", 1'b1, 4'b0001);
    pulse_frame("coll_empty", 1'b0, 4'b0000);
  endtask

  task automatic test_blanking();
    player_x = 10'd100;
    clear_obst();
    set_obst(0, 110, 320, 40, 40, 1'b1);
    x = 10'd115; y = 10'd325; active_pixels = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== C_OFF || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL blank_rgb: rgb=%06h pv=%b, required rgb=000000 pv=0",
               {VGA_R, VGA_G, VGA_B}, pix_valid);
    end else begin
      $display("blanking inside player box rgb=000000");
    end
    pulse_frame("blank_nohit", 1'b0, 4'b0000);
  endtask

  task automatic test_async_reset();
    player_x = 10'd100;
    clear_obst();
    set_obst(0, 110, 320, 40, 40, 1'b1);
    check_pixel("ar_hit", 115, 325, C_PL);
    pulse_frame("ar_latch", 1'b1, 4'b0001);
    check_pixel("ar_hit2", 115, 325, C_PL);
    x = 10'd400; y = 10'd50; active_pixels = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== C_BG) begin
      errors++;
      $display("FAIL ar_pre: rgb=%06h, required %06h", {VGA_R, VGA_G, VGA_B}, C_BG);
    end
    // Assert reset between clock edges; the outputs must clear without an edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if (collision !== 1'b0 || collision_mask !== 4'b0000 ||
        {VGA_R, VGA_G, VGA_B} !== C_OFF || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear: col=%b mask=%b rgb=%06h pv=%b, required all zero",
               collision, collision_mask, {VGA_R, VGA_G, VGA_B}, pix_valid);
    end else begin
      $display("async reset cleared outputs mid-cycle");
    end
    active_pixels = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    pulse_frame("ar_first", 1'b0, 4'b0000);
  endtask

  task automatic test_outline();
    logic [23:0] exp_edge;
`ifdef VGA_RENDER_OUTLINE_EN
    exp_edge = C_WH;
`else
    exp_edge = C_OB;
`endif
    clear_obst();
    set_obst(0, 200, 100, 10, 10, 1'b1);
    check_pixel("outline_left", 200, 105, exp_edge);
    check_pixel("outline_bottom", 205, 109, exp_edge);
    check_pixel("outline_inner", 205, 105, C_OB);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_edge_wrap();
    test_collision();
    test_blanking();
    test_async_reset();
    test_outline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
